// File: rtl/mult_rr_scheduler_pkg.sv
// Shared types and constants for the round-robin multiplier scheduler.
package mult_rr_scheduler_pkg;

  localparam int DP_WIDTH_DEF = 5;
  localparam int N_REQ_DEF    = 4;
  localparam int WDOG_LO      = 4;
  localparam int WDOG_HI      = 256;
  localparam int WDOG_W       = $clog2(WDOG_HI);

  typedef enum logic [4:0] {
    IDLE    = 5'b00001,
    LAUNCH  = 5'b00010,
    WAIT_LO = 5'b00100,
    WAIT_HI = 5'b01000,
    RESP    = 5'b10000
  } sched_state_t;

  function automatic int unsigned wrap_inc(input int unsigned idx, input int unsigned n);
    return (idx + 1 >= n) ? 0 : idx + 1;
  endfunction

endpackage

// File: rtl/mult_rr_scheduler_rr_pick.sv
// Combinational round-robin picker: first asserted request at or after ptr, wrapping.
module rr_pick
  import mult_rr_scheduler_pkg::*;
#(
  parameter int N_REQ = N_REQ_DEF,
  parameter int PW    = $clog2(N_REQ)
) (
  input  logic [N_REQ-1:0] req,
  input  logic [PW-1:0]    ptr,
  output logic             any,
  output logic [N_REQ-1:0] win_oh,
  output logic [PW-1:0]    win_idx
);

  logic [PW:0] cand;

  always_comb begin
    any     = 1'b0;
    win_oh  = '0;
    win_idx = '0;
    cand    = '0;
    for (int k = 0; k < N_REQ; k++) begin
      cand = {1'b0, ptr} + (PW+1)'(k);
      if (cand >= (PW+1)'(N_REQ)) cand = cand - (PW+1)'(N_REQ);
      if (!any && req[cand[PW-1:0]]) begin
        any                  = 1'b1;
        win_idx              = cand[PW-1:0];
        win_oh[cand[PW-1:0]] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/mult_rr_scheduler.sv
// Shares one start/rdy sequential multiplier among N_REQ requesters, round-robin.
//
// state   | meaning
// IDLE    | waiting for a request while the multiplier is ready; grants on entry to LAUNCH
// LAUNCH  | gnt pulse, operands held on mult_a/mult_b
// WAIT_LO | mult_start pulse, waiting for multiplier to drop rdy (watchdog WDOG_LO)
// WAIT_HI | multiplier running, waiting for rdy (watchdog WDOG_HI)
// RESP    | done pulse to the winner, pointer advances past it
module mult_rr_scheduler
  import mult_rr_scheduler_pkg::*;
#(
  parameter int N_REQ    = N_REQ_DEF,
  parameter int DP_WIDTH = DP_WIDTH_DEF
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [N_REQ-1:0]          req,
  input  logic [N_REQ*DP_WIDTH-1:0] req_a,
  input  logic [N_REQ*DP_WIDTH-1:0] req_b,
  output logic [N_REQ-1:0]          gnt,
  output logic [N_REQ-1:0]          done,
  output logic [2*DP_WIDTH-1:0]     result,
  output logic                      busy,
  output logic                      mult_start,
  output logic [DP_WIDTH-1:0]       mult_a,
  output logic [DP_WIDTH-1:0]       mult_b,
  input  logic                      mult_rdy,
  input  logic [2*DP_WIDTH-1:0]     mult_prod
);

  localparam int PW = $clog2(N_REQ);

  sched_state_t       state;
  logic [PW-1:0]      ptr;
  logic [PW-1:0]      w_idx;
  logic [N_REQ-1:0]   w_oh;
  logic [WDOG_W-1:0]  wdog;
  logic               err;

  logic               pick_any;
  logic [N_REQ-1:0]   pick_oh;
  logic [PW-1:0]      pick_idx;

  rr_pick #(
    .N_REQ (N_REQ),
    .PW    (PW)
  ) u_pick (
    .req     (req),
    .ptr     (ptr),
    .any     (pick_any),
    .win_oh  (pick_oh),
    .win_idx (pick_idx)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      ptr        <= '0;
      w_idx      <= '0;
      w_oh       <= '0;
      wdog       <= '0;
      err        <= 1'b0;
      gnt        <= '0;
      done       <= '0;
      result     <= '0;
      busy       <= 1'b0;
      mult_start <= 1'b0;
      mult_a     <= '0;
      mult_b     <= '0;
    end else begin
      gnt        <= '0;
      done       <= '0;
      mult_start <= 1'b0;
      case (state)
        IDLE: begin
          if (pick_any && mult_rdy) begin
            gnt    <= pick_oh;
            w_oh   <= pick_oh;
            w_idx  <= pick_idx;
            mult_a <= req_a[32'(pick_idx)*DP_WIDTH +: DP_WIDTH];
            mult_b <= req_b[32'(pick_idx)*DP_WIDTH +: DP_WIDTH];
            busy   <= 1'b1;
            state  <= LAUNCH;
          end
        end
        LAUNCH: begin
          mult_start <= 1'b1;
          wdog       <= WDOG_W'(WDOG_LO - 1);
          state      <= WAIT_LO;
        end
        WAIT_LO: begin
          // rdy is still high during the start cycle itself; that cycle counts toward the limit
          if (!mult_rdy) begin
            wdog  <= WDOG_W'(WDOG_HI - 1);
            state <= WAIT_HI;
          end else if (wdog == '0) begin
            err   <= 1'b1;
            busy  <= 1'b0;
            state <= IDLE;
          end else begin
            wdog <= wdog - 1'b1;
          end
        end
        WAIT_HI: begin
          if (mult_rdy) begin
            result <= mult_prod;
            done   <= w_oh;
            state  <= RESP;
          end else if (wdog == '0) begin
            err   <= 1'b1;
            busy  <= 1'b0;
            state <= IDLE;
          end else begin
            wdog <= wdog - 1'b1;
          end
        end
        RESP: begin
          busy  <= 1'b0;
          ptr   <= PW'(wrap_inc(32'(w_idx), N_REQ));
          state <= IDLE;
        end
        default: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule
